// File: rtl/permutation_iter_if.sv
// Start/done handshake and state bus between the mode FSM and the Ascon permutation engine.
// The state is five 64-bit words with x0 in the most significant position.
interface permutation_iter_if;
   logic                 start_i;
   logic [1:0]           nb_rounds_i;
   logic [0:4][63:0]     state_i;
   logic [0:4][63:0]     state_o;
   logic [3:0]           round_o;
   logic                 busy_o;
   logic                 done_o;

   modport master (
      output start_i, nb_rounds_i, state_i,
      input  state_o, round_o, busy_o, done_o
   );

   modport slave (
      input  start_i, nb_rounds_i, state_i,
      output state_o, round_o, busy_o, done_o
   );
endinterface

// File: rtl/permutation_iter.sv
// Iterative Ascon permutation (p12/p8/p6) applying UNROLL full rounds per clock,
// with a registered start/done handshake and round counter.
module permutation_iter #(
   parameter int UNROLL = 1
) (
   input  logic              clock_i,
   input  logic              resetb_i,
   permutation_iter_if.slave bus
);

   typedef logic [0:4][63:0] type_state;
   typedef enum logic {IDLE, RUN} fsm_t;

   if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
      $error("permutation_iter: UNROLL must be 1 or 2");
   end

   function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned a);
      return (x >> a) | (x << (64 - a));
   endfunction

   // One full round: constant addition, bit-sliced S-box, linear diffusion.
   function automatic type_state ascon_round(input type_state s, input logic [3:0] r);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      x0 = s[0];
      x1 = s[1];
      x2 = s[2] ^ {56'd0, 4'hF - r, r};
      x3 = s[3];
      x4 = s[4];
      x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
      x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
      x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

   fsm_t       fsm_q, fsm_d;
   type_state  state_q, state_d;
   type_state  rnd_state;
   logic [3:0] round_q, round_d;
   logic [3:0] first_round;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   always_comb begin
      // Reserved encoding 11 runs the full p12.
      unique case (bus.nb_rounds_i)
         2'b01:   first_round = 4'd4;
         2'b10:   first_round = 4'd6;
         default: first_round = 4'd0;
      endcase
   end

   always_comb begin
      // NOTE: blocking assignments here so each unrolled round feeds the next within the same cycle.
      rnd_state = state_q;
      for (int u = 0; u < UNROLL; u++) begin
         rnd_state = ascon_round(rnd_state, round_q + 4'(u));
      end
   end

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      round_d = round_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (fsm_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d = bus.state_i;
               round_d = first_round;
               busy_d  = 1'b1;
               fsm_d   = RUN;
            end
         end
         RUN: begin
            state_d = rnd_state;
            // Round counts 12, 8 and 6 all start on a multiple of UNROLL, so equality is exact.
            if (round_q == 4'(12 - UNROLL)) begin
               round_d = 4'd0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               fsm_d   = IDLE;
            end else begin
               round_d = round_q + 4'(UNROLL);
            end
         end
      endcase
   end

   // NOTE: non-blocking in the clocked block; all state flops take their reset value asynchronously.
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         round_q <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         round_q <= round_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.state_o = state_q;
   assign bus.round_o = round_q;
   assign bus.busy_o  = busy_q;
   assign bus.done_o  = done_q;

endmodule

// File: tb/tb_permutation_iter.sv
// Directed bench for permutation_iter (UNROLL=1 and UNROLL=2 instances) with an
// independent table-driven Ascon model feeding an expected-result queue.
module tb_permutation_iter;

   typedef logic [0:4][63:0] type_state;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   permutation_iter_if ifa ();
   permutation_iter_if ifb ();

   permutation_iter #(.UNROLL(1)) dut_u1 (.clock_i(clk), .resetb_i(rst_n), .bus(ifa));
   permutation_iter #(.UNROLL(2)) dut_u2 (.clock_i(clk), .resetb_i(rst_n), .bus(ifb));

   int n_assert = 0;
   int n_fail   = 0;
   type_state exp_q [$];

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
   localparam logic [7:0] RC [12] = '{
      8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
   localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
   localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

   task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rotr(input logic [63:0] x, input int a);
      logic [127:0] d;
      d = {x, x};
      d = d >> a;
      return d[63:0];
   endfunction

   function automatic type_state model_round(input type_state s, input int r);
      type_state t, o;
      logic [4:0] col;
      t = s;
      t[2][7:0] = t[2][7:0] ^ RC[r];
      o = '0;
      for (int b = 0; b < 64; b++) begin
         col = SBOX[{t[0][b], t[1][b], t[2][b], t[3][b], t[4][b]}];
         for (int w = 0; w < 5; w++) o[w][b] = col[4 - w];
      end
      for (int w = 0; w < 5; w++) o[w] = o[w] ^ rotr(o[w], ROT_A[w]) ^ rotr(o[w], ROT_B[w]);
      return o;
   endfunction

   function automatic int nrounds(input logic [1:0] nb);
      case (nb)
         2'b01:   return 8;
         2'b10:   return 6;
         default: return 12;
      endcase
   endfunction

   function automatic type_state model_steps(input type_state s, input int first, input int cnt);
      type_state t = s;
      for (int i = 0; i < cnt; i++) t = model_round(t, first + i);
      return t;
   endfunction

   function automatic type_state rand_state();
      type_state t;
      for (int w = 0; w < 5; w++) t[w] = {$urandom, $urandom};
      return t;
   endfunction

   task automatic drive(input int sel, input logic st, input logic [1:0] nb, input type_state s);
      if (sel == 0) begin
         ifa.start_i = st; ifa.nb_rounds_i = nb; ifa.state_i = s;
      end else begin
         ifb.start_i = st; ifb.nb_rounds_i = nb; ifb.state_i = s;
      end
   endtask

   function automatic type_state o_state(input int sel);
      return (sel == 0) ? ifa.state_o : ifb.state_o;
   endfunction
   function automatic logic [3:0] o_round(input int sel);
      return (sel == 0) ? ifa.round_o : ifb.round_o;
   endfunction
   function automatic logic o_busy(input int sel);
      return (sel == 0) ? ifa.busy_o : ifb.busy_o;
   endfunction
   function automatic logic o_done(input int sel);
      return (sel == 0) ? ifa.done_o : ifb.done_o;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag, input int sel);
      check({tag, ":state"}, o_state(sel), '0);
      check({tag, ":round"}, o_round(sel), 0);
      check({tag, ":busy"},  o_busy(sel),  0);
      check({tag, ":done"},  o_done(sel),  0);
   endtask

   // Present a start for one edge; the expected result is queued at acceptance.
   task automatic start_perm(input int sel, input type_state s, input logic [1:0] nb, input bit hold);
      drive(sel, 1'b1, nb, s);
      exp_q.push_back(model_steps(s, 12 - nrounds(nb), nrounds(nb)));
      step();
      if (!hold) drive(sel, 1'b0, nb, ~s);
   endtask

   // Called just after the accepting edge; follows the run until done and checks the scoreboard.
   task automatic wait_done(input int sel, input string tag, input type_state s, input logic [1:0] nb,
                            input int poke_cyc, input type_state poke_s,
                            input bit chain, input type_state chain_s);
      int n     = nrounds(nb);
      int u     = (sel == 0) ? 1 : 2;
      int first = 12 - n;
      int cyc   = 0;
      type_state exp;
      while (o_done(sel) !== 1'b1 && cyc <= 20) begin
         check({tag, ":busy"},  o_busy(sel),  1);
         check({tag, ":round"}, o_round(sel), first + cyc * u);
         if (cyc == 1) check({tag, ":first_step"}, o_state(sel), model_steps(s, first, u));
         if (cyc == poke_cyc) drive(sel, 1'b1, 2'b10, poke_s);
         step();
         if (cyc == poke_cyc) drive(sel, 1'b0, nb, s);
         cyc++;
      end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check({tag, ":cycles"},     cyc,          n / u);
      check({tag, ":done"},       o_done(sel),  1);
      check({tag, ":busy_done"},  o_busy(sel),  0);
      check({tag, ":round_done"}, o_round(sel), 0);
      check({tag, ":result"},     o_state(sel), exp);
      if (chain) exp_q.push_back(model_steps(chain_s, 12 - n, n));
      step();
      check({tag, ":done_pulse"}, o_done(sel), 0);
      if (chain) begin
         drive(sel, 1'b0, nb, chain_s);
         check({tag, ":chain_busy"}, o_busy(sel), 1);
      end else begin
         check({tag, ":hold"}, o_state(sel), exp);
      end
   endtask

   initial begin
      type_state iv, sa, sb;
      iv = {64'h80400c0600000000, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaaff,
            64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a};

      // Reset held with an active start request on both instances.
      drive(0, 1'b1, 2'b00, rand_state());
      drive(1, 1'b1, 2'b00, rand_state());
      repeat (3) step();
      check_idle("rst_u1", 0);
      check_idle("rst_u2", 1);
      drive(0, 1'b0, 2'b00, rand_state());
      drive(1, 1'b0, 2'b00, rand_state());
      rst_n = 1'b1;
      repeat (10) step();
      check_idle("idle_u1", 0);
      check_idle("idle_u2", 1);

      // p12 on the init vector.
      start_perm(0, iv, 2'b00, 1'b0);
      wait_done(0, "p12_u1", iv, 2'b00, -1, '0, 1'b0, '0);

      // p6 and p8 on random states.
      sa = rand_state();
      start_perm(0, sa, 2'b10, 1'b0);
      wait_done(0, "p6_u1", sa, 2'b10, -1, '0, 1'b0, '0);
      sa = rand_state();
      start_perm(0, sa, 2'b01, 1'b0);
      wait_done(0, "p8_u1", sa, 2'b01, -1, '0, 1'b0, '0);

      // Start pulse in RUN cycle 3 with a different state is ignored.
      sa = rand_state();
      sb = rand_state();
      start_perm(0, sa, 2'b00, 1'b0);
      wait_done(0, "poke_u1", sa, 2'b00, 3, sb, 1'b0, '0);

      // Start held high through the run and the done cycle: second run accepted at done.
      sa = rand_state();
      sb = rand_state();
      start_perm(0, sa, 2'b00, 1'b1);
      drive(0, 1'b1, 2'b00, sb);
      wait_done(0, "chain1_u1", sa, 2'b00, -1, '0, 1'b1, sb);
      wait_done(0, "chain2_u1", sb, 2'b00, -1, '0, 1'b0, '0);

      // Asynchronous reset between edges in RUN cycle 5.
      sa = rand_state();
      start_perm(0, sa, 2'b00, 1'b0);
      repeat (5) step();
      #2 rst_n = 1'b0;
      #1;
      check_idle("midrst_u1", 0);
      exp_q.delete();
      repeat (2) step();
      rst_n = 1'b1;
      repeat (14) begin
         step();
         check("midrst_no_done", o_done(0), 0);
      end
      check_idle("midrst_after", 0);
      sa = rand_state();
      start_perm(0, sa, 2'b00, 1'b0);
      wait_done(0, "post_rst_u1", sa, 2'b00, -1, '0, 1'b0, '0);

      // UNROLL=2 instance: init vector, reserved encoding, p6.
      start_perm(1, iv, 2'b00, 1'b0);
      wait_done(1, "p12_u2", iv, 2'b00, -1, '0, 1'b0, '0);
      sa = rand_state();
      start_perm(1, sa, 2'b11, 1'b0);
      wait_done(1, "p11_u2", sa, 2'b11, -1, '0, 1'b0, '0);
      sa = rand_state();
      start_perm(1, sa, 2'b10, 1'b0);
      wait_done(1, "p6_u2", sa, 2'b10, -1, '0, 1'b0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/permutation_iter.md
# permutation_iter

Iterative Ascon permutation engine, the parametrised successor of the combinational constant-addition stage. It registers a 320-bit `type_state`, then applies a full Ascon round per step: constant addition, 5-bit S-box layer, linear diffusion. It applies the rounds over multiple cycles, with a selectable round count (p12, p8, p6) and a configurable number of rounds unrolled per cycle. It sits between the mode FSM (init / associated data / plaintext / finalisation) and the state register path, and is driven by a start/done handshake.

## Interface
- `UNROLL`, default 1: rounds computed per clock cycle; legal values 1 and 2 (must divide 6, 8 and 12); any other value is a elaboration error.
- `clock_i`  in  1  system clock, rising-edge.
- `resetb_i`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start_i`  in  1  request a permutation on `state_i`; sampled only in IDLE.
- `nb_rounds_i`  in  2  00: 12 rounds, 01: 8 rounds, 10: 6 rounds, 11: reserved, treated as 12; sampled with `start_i`.
- `state_i`  in  320 (`type_state`, 5×64)  input state, sampled with `start_i`.
- `state_o`  out  320  state register; holds the result after `done_o` until the next accepted start.
- `round_o`  out  4  round index of the next round to apply (12−n … 11); 0 in IDLE.
- `busy_o`  out  1  high while a permutation is in progress.
- `done_o`  out  1  registered one-cycle pulse; `state_o` is final in that cycle.

## Operation
- FSM states are IDLE and RUN.
- **IDLE, `start_i`=1:**
  - Load `state_i` into the state register without applying a round.
  - Set the round counter to 12−n, where n is the decoded `nb_rounds_i`.
  - `busy_o`←1; go to RUN.
- **IDLE, `start_i`=0:** hold all registers.
- **RUN, each cycle:**
  - Apply UNROLL consecutive rounds with indices r, r+1, …
  - Advance the counter by UNROLL.
  - When the last round (index 11) is applied: `busy_o`←0, `done_o`←1 for one cycle, `round_o`←0, go to IDLE.
- **Round r:**
  - Constant addition: x2[7:0] ^= {4'hF−r, r}, giving 0xF0, 0xE1, 0xD2, 0xC3, 0xB4, 0xA5, 0x96, 0x87, 0x78, 0x69, 0x5A, 0x4B for r = 0…11.
  - Substitution: the standard Ascon 5-bit S-box, applied per bit column (x0 is the MSB of the column).
  - Linear layer, right rotations: x0: 19, 28; x1: 61, 39; x2: 1, 6; x3: 10, 17; x4: 7, 41. Each word is xᵢ ^= ROR(xᵢ,a) ^ ROR(xᵢ,b).
- **`start_i` while RUN:** ignored. No queuing, and no restart of the running permutation.
- **`start_i` in the cycle `done_o`=1:** accepted, because the FSM is already in IDLE. The new state is loaded, overwriting the result, and `done_o` falls.
- **`nb_rounds_i` / `state_i` changes during RUN:** no effect.

## Timing
- **Reset values:** `state_o`=0, `round_o`=0, `busy_o`=0, `done_o`=0, FSM=IDLE. Assertion takes effect immediately, including mid-permutation; any pending result is discarded and no `done_o` is emitted.
- **Latency:** with `start_i` sampled at edge k, rounds are applied at edges k+1 … k+n/UNROLL. `done_o` and the final `state_o` are visible after edge k+n/UNROLL.
  - UNROLL=1: 12, 8 or 6 cycles.
  - UNROLL=2: 6, 4 or 3 cycles.
- **`busy_o`:** high from edge k to edge k+n/UNROLL, exactly n/UNROLL cycles; it never overlaps `done_o`.
- **Throughput:** one permutation every n/UNROLL+1 cycles when back-to-back starts use the done-cycle acceptance. This holds because the start is accepted in the done cycle and the load takes one edge.
- **Critical path:** UNROLL × (constant XOR + S-box + rotation XOR).

## Test plan
- **Reset behaviour:** hold `resetb_i`=0 with random `state_i` and `start_i`=1 → all outputs 0 and `busy_o`=0. Release, then keep `start_i`=0 for 10 cycles → outputs unchanged.
- **p12 on the init state, UNROLL=1:** `state_i`={0x80400c0600000000, 0x8a55114d1cb6a9a2, 0xbe263d4d7aecaaff, 0x4ed0ec0b98c529b7, 0xc8cddf37bcd0284a}, `nb_rounds_i`=00, start pulse.
  - `busy_o` high for exactly 12 cycles.
  - `round_o` steps 0…11.
  - `done_o` rises after the 12th round edge.
  - `state_o` equals the bench reference-model p12 output.
- **p6 constants:** `nb_rounds_i`=10 → `round_o` steps 6…11.
  - After the first round, x2 matches the model with constant 0x96; after the last round, with constant 0x4B.
  - `done_o` after 6 cycles.
  - `nb_rounds_i`=01 gives `done_o` after 8 cycles, starting at r=4 (0xB4).
- **Handshake:**
  - A `start_i` pulse at RUN cycle 3 with a different `state_i` → ignored; the result matches the first input.
  - `start_i` held high through the `done_o` cycle → the second permutation is accepted there, and the next `done_o` arrives exactly 12 cycles later.
- **Reset mid-run:** assert `resetb_i`=0 asynchronously at RUN cycle 5 (between edges) → outputs 0 immediately and no `done_o` follows. A new start then completes normally.
- **UNROLL=2 build:** same vector as the p12 scenario → identical `state_o`, `done_o` after 6 cycles, `round_o` steps 0, 2, 4…10. `nb_rounds_i`=11 behaves as 12.
